// File: rtl/clk_divider.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider
//  Description : Integer clock divider. Produces a registered, glitch-free
//                square wave at f(clk_in)/DIVISOR. It also produces a
//                single-cycle strobe that marks each rising edge of the
//                divided clock.
//  Parameters  : DIVISOR - division ratio, integer >= 2
//                CNT_W   - phase counter width, derived from DIVISOR
//  Ports       : clk_in  - source clock; all state updates on its rising edge
//                rst     - asynchronous, active-high reset
//                clk_out - divided clock: low for ceil(DIVISOR/2) cycles,
//                          then high for the rest of the period
//                tick    - high for one clk_in cycle when clk_out has just
//                          gone 0->1 (preferred clock-enable for consumers)
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider #(
    parameter int DIVISOR = 2,
    parameter int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out,
    output logic tick
);

    // Reject nonsensical configurations at elaboration time.
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("clk_divider: DIVISOR must be >= 2 (got %0d)", DIVISOR);
    end
    if ((DIVISOR > 2) && (CNT_W < $clog2(DIVISOR))) begin : g_bad_cnt_w
        $error("clk_divider: CNT_W=%0d too narrow for DIVISOR=%0d", CNT_W, DIVISOR);
    end

    // Terminal count of the phase counter, and the count at which the
    // output enters its high phase. The low phase is the longer one when
    // DIVISOR is odd.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] c_HALF = CNT_W'((DIVISOR + 1) / 2);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic [CNT_W-1:0] w_cnt_next;

    // Wrap explicitly at DIVISOR-1. For non-power-of-two ratios the counter
    // therefore never visits values >= DIVISOR.
    assign w_cnt_next = (r_cnt == c_LAST) ? '0 : (r_cnt + c_ONE);

    // Both outputs are decoded from the next count and then registered.
    // The outputs change only on clk_in edges or on reset assertion, so
    // clk_out is safe to use as a clock.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_clk_out <= (w_cnt_next >= c_HALF);
            r_tick    <= (w_cnt_next == c_HALF);
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_divider
//  Description : Self-checking bench for clk_divider. Five instances
//                (DIVISOR 2, 3, 4, 5, 12000) share one clock and one reset.
//                An independent reference model pushes the expected outputs
//                for every edge into a queue. Each expected entry is popped
//                and compared after the edge. Directed checks cover:
//                - async reset
//                - reset release coincident with a clock edge
//                - the small-divisor waveforms
//                - a reset asserted mid-high-phase
//                - period/duty/tick statistics over a long run
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_divider;

    localparam int N = 5;
    localparam int DIVS [N] = '{2, 3, 4, 5, 12000};
    localparam int LONG_RUN = 20000;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b0;
    logic [N-1:0] clk_out;
    logic [N-1:0] tick;

    always #5 clk_in = ~clk_in;

    clk_divider #(.DIVISOR(2))     u_d2     (.clk_in(clk_in), .rst(rst), .clk_out(clk_out[0]), .tick(tick[0]));
    clk_divider #(.DIVISOR(3))     u_d3     (.clk_in(clk_in), .rst(rst), .clk_out(clk_out[1]), .tick(tick[1]));
    clk_divider #(.DIVISOR(4))     u_d4     (.clk_in(clk_in), .rst(rst), .clk_out(clk_out[2]), .tick(tick[2]));
    clk_divider #(.DIVISOR(5))     u_d5     (.clk_in(clk_in), .rst(rst), .clk_out(clk_out[3]), .tick(tick[3]));
    clk_divider #(.DIVISOR(12000)) u_d12000 (.clk_in(clk_in), .rst(rst), .clk_out(clk_out[4]), .tick(tick[4]));

    typedef struct packed {
        logic [N-1:0] o;
        logic [N-1:0] t;
    } exp_t;

    exp_t         sbq [$];
    int           m_cnt [N];
    logic [N-1:0] m_out;
    logic [N-1:0] m_tick;

    int n_checks = 0;
    int n_err    = 0;

    // Long-run statistics
    int   d12k_rise1 = -1;
    int   d12k_fall1 = -1;
    int   d12k_rise2 = -1;
    int   d12k_ticks = 0;
    int   d5_ticks   = 0;
    int   d5_run     = 0;
    int   d5_max_cnt = 0;
    bit   d5_seen_rise = 1'b0;
    logic prev4 = 1'b0;
    logic prev3 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one clk_in edge with the given reset level.
    task automatic model_edge(input logic r);
        for (int i = 0; i < N; i++) begin
            if (r) begin
                m_cnt[i]  = 0;
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end else begin
                int nxt;
                int half;
                half      = (DIVS[i] + 1) / 2;
                nxt       = (m_cnt[i] == DIVS[i] - 1) ? 0 : m_cnt[i] + 1;
                m_cnt[i]  = nxt;
                m_out[i]  = (nxt >= half);
                m_tick[i] = (nxt == half);
            end
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("clk_out", 32'(clk_out), 32'(e.o));
            chk("tick", 32'(tick), 32'(e.t));
        end
    endtask

    // One clock edge with rst held at its current level.
    task automatic step();
        model_edge(rst);
        sbq.push_back(exp_t'{m_out, m_tick});
        @(posedge clk_in);
        #1;
        check_pop();
    endtask

    // Deassert rst exactly on a clock edge. The edge itself must still see reset.
    task automatic release_edge();
        model_edge(1'b1);
        sbq.push_back(exp_t'{m_out, m_tick});
        @(posedge clk_in);
        rst <= 1'b0;
        #1;
        check_pop();
    endtask

    task automatic stats(input int e);
        int c5;
        // DIVISOR=12000: edge positions of the first rise, first fall and
        // second rise, plus a count of ticks.
        if (clk_out[4] && !prev4) begin
            if (d12k_rise1 < 0) d12k_rise1 = e;
            else if (d12k_rise2 < 0) d12k_rise2 = e;
        end
        if (!clk_out[4] && prev4 && d12k_fall1 < 0) d12k_fall1 = e;
        if (tick[4]) d12k_ticks++;
        prev4 = clk_out[4];

        // DIVISOR=5: every completed phase must be 3 low or 2 high. The
        // partial low phase before the first rise is skipped.
        if (clk_out[3] != prev3) begin
            if (clk_out[3]) begin
                if (d5_seen_rise) chk("d5_low_len", 32'(d5_run), 32'd3);
                d5_seen_rise = 1'b1;
            end else begin
                chk("d5_high_len", 32'(d5_run), 32'd2);
            end
            d5_run = 1;
        end else begin
            d5_run++;
        end
        prev3 = clk_out[3];
        if (tick[3]) d5_ticks++;
        c5 = int'(u_d5.r_cnt);
        if (c5 > d5_max_cnt) d5_max_cnt = c5;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_edge(1'b1);

        // Assert reset before any clock edge. The outputs must clear asynchronously.
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out", 32'(clk_out), 32'd0);
        chk("async_reset_tick", 32'(tick), 32'd0);

        // Hold reset for 20 edges.
        for (int k = 0; k < 20; k++) step();

        // Release reset on an edge. Then check the small-divisor waveforms.
        release_edge();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("d2_out", 32'(clk_out[0]), 32'(k % 2));
            chk("d2_tick", 32'(tick[0]), 32'(k % 2));
            chk("d3_out", 32'(clk_out[1]), 32'((k % 3) == 2));
            chk("d3_tick", 32'(tick[1]), 32'((k % 3) == 2));
        end

        // After 10 edges, DIVISOR=4 is in its high phase (count 2).
        // Assert reset between edges and check that it acts immediately.
        chk("d4_high_before_rst", 32'(clk_out[2]), 32'd1);
        #3 rst = 1'b1;
        #1;
        model_edge(1'b1);
        chk("midphase_rst_out", 32'(clk_out), 32'd0);
        chk("midphase_rst_tick", 32'(tick), 32'd0);
        for (int k = 0; k < 3; k++) step();

        // Release reset on an edge again, then run the long sequence.
        release_edge();
        for (int e = 1; e <= LONG_RUN; e++) begin
            step();
            if (e == 1) chk("d4_after_edge1", 32'(clk_out[2]), 32'd0);
            if (e == 2) chk("d4_rise_edge2", 32'(clk_out[2]), 32'd1);
            stats(e);
        end

        chk("d12k_first_rise", 32'(d12k_rise1), 32'd6000);
        chk("d12k_first_fall", 32'(d12k_fall1), 32'd12000);
        chk("d12k_second_rise", 32'(d12k_rise2), 32'd18000);
        chk("d12k_ticks", 32'(d12k_ticks), 32'd2);
        chk("d5_ticks", 32'(d5_ticks), 32'd4000);
        chk("d5_max_cnt", 32'(d5_max_cnt), 32'd4);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_divider.md
Name: clk_divider

Overview:
- Integer clock divider. It produces a free-running, glitch-free square wave `clk_out` at f(clk_in)/DIVISOR, plus a single-cycle `tick` strobe marking each rising edge of `clk_out`.
- Used as the slow timebase for LED/PWM-style logic, e.g. 24 MHz / 12000 = 2 kHz blur clock.
- Fully synchronous to `clk_in`, except the reset.

Parameters:
- DIVISOR, default 2: division ratio, integer >= 2. Values < 2 are an elaboration error ($error / fatal).
- CNT_W, default max(1, $clog2(DIVISOR)): counter width. Derived; not to be overridden.

Ports:
- clk_in  input  1  source clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- clk_out  output  1  divided clock, registered (no combinational path from clk_in).
- tick  output  1  one clk_in-cycle pulse, high in the cycle in which clk_out has just gone 0->1.

Behaviour:
- Internal counter `cnt` [CNT_W-1:0] counts 0..DIVISOR-1 and wraps.
- Let L = ceil(DIVISOR/2), i.e. (DIVISOR+1)/2 in integer arithmetic.
- Reset (rst=1, asynchronous): cnt=0, clk_out=0, tick=0 immediately, without waiting for a clk_in edge. Outputs hold these values for as long as rst is high.
- Each rising edge of clk_in with rst=0:
  - cnt_next = (cnt == DIVISOR-1) ? 0 : cnt+1; cnt <= cnt_next.
  - clk_out <= (cnt_next >= L).
  - tick <= (cnt_next == L).
- Resulting waveform:
  - Period is exactly DIVISOR clk_in cycles.
  - clk_out is low for L cycles, then high for DIVISOR-L cycles.
  - Even DIVISOR gives exact 50% duty. Odd DIVISOR gives low one cycle longer than high.
- Latency: the first clk_out rising edge occurs at the L-th clk_in rising edge after rst deasserts. Subsequent rising edges follow every DIVISOR edges.
- tick:
  - Exactly one high cycle per period, aligned with the clk_out 0->1 transition.
  - Never high two consecutive cycles (DIVISOR >= 2 guarantees this).
- Wrap: cnt = DIVISOR-1 -> 0. If DIVISOR is not a power of two, cnt never reaches values >= DIVISOR.
- Reset mid-period:
  - Any phase is abandoned immediately.
  - clk_out goes low asynchronously, even mid-high-phase; tick is cleared.
  - After release the sequence restarts from cnt=0 with no partial pulse.
- Reset release coincident with a clk_in edge: that edge is ignored (state stays at reset values); counting begins on the next edge.
- clk_out changes only on clk_in rising edges or on rst assertion, so there are no glitches.
- Downstream logic may use clk_out as a clock; tick is provided as the preferred clock-enable alternative.

Test Plan:
- DIVISOR=2, release rst, run 10 edges -> clk_out toggles every edge (0 before first edge, 1 after edge 1, 0 after edge 2, ...). tick high after edges 1, 3, 5, 7, 9 only.
- DIVISOR=3, run 9 edges after reset -> clk_out pattern after each edge: 0,1,0,0,1,0,0,1,0. Low 2 cycles, high 1 cycle. tick coincides with each 1.
- DIVISOR=12000 → clk_out period:
  - first rise at edge 6000; falls at edge 12000; next rise at edge 18000.
  - period 12000, duty 50%.
  - tick count over 120000 edges = 10.
- Assert rst asynchronously midway through a high phase (DIVISOR=4, between edges 2 and 3) -> clk_out and tick go 0 before the next clk_in edge. After release, first rise occurs at edge 2.
- Hold rst high for 20 edges -> clk_out=0 and tick=0 throughout. Deassert coincident with a clk_in edge -> that edge is ignored, and the first rise lands L edges after it.
- Long run of 1e5 edges, DIVISOR=5 → periodicity:
  - every clk_out period is exactly 5 cycles (3 low / 2 high);
  - ticks = 20000;
  - cnt never exceeds 4.
